// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_seq program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_e;

  localparam int unsigned PC_W_DEF = 11;
  localparam int unsigned NUM_BASE = 3;

  localparam logic [PC_W_DEF-1:0] PROG_BASE [NUM_BASE] = '{11'd0, 11'd256, 11'd512};

  // Entry-point lookup; indices past the table fall back to entry 0.
  function automatic logic [PC_W_DEF-1:0] prog_base_at(input int unsigned idx);
    logic [PC_W_DEF-1:0] res;
    res = PROG_BASE[0];
    for (int unsigned i = 1; i < NUM_BASE; i++) begin
      if (idx == i) res = PROG_BASE[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int unsigned W     = PC_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_c     = (cnt_q == CNT_W'(DEPTH));
  assign empty_c    = (cnt_q == '0);
  assign pop_data_c = mem_q[ptr_q - PTR_W'(1)];

  // ptr_q is the next write slot; count saturates so a full push keeps it at DEPTH.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (pop && !empty_c) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_c) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !pop) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with entry-point load, branches, calls and returns.
// Define PC_SEQ_RAS_EN to build the return-address stack; without it calls are plain jumps.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned NUM_PROGS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(NUM_PROGS)-1:0] prog_sel,
  input  logic                         branch_en,
  input  logic                         alu_flag,
  input  logic                         br_abs,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic                         halt_en,
  input  logic [PC_W-1:0]              target,
  output logic [PC_W-1:0]              prog_ctr,
  output logic                         done,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [PC_W-1:0]   pc_inc_c;
  logic [PC_W-1:0]   base_c;
  logic              ras_push_c, ras_pop_c, ras_clear_c;
  logic              ras_full_c, ras_empty_c, ret_req_c;
  logic [PC_W-1:0]   ras_top_c;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .clear      (ras_clear_c),
    .push       (ras_push_c),
    .pop        (ras_pop_c),
    .push_data  (pc_inc_c),
    .pop_data_c (ras_top_c),
    .full_c     (ras_full_c),
    .empty_c    (ras_empty_c)
  );

  assign ret_req_c = ret_en;
`else
  localparam bit RAS_ON = 1'b0;
  logic ras_unused;

  // Without a stack, returns are dropped and the priority falls through.
  assign ret_req_c   = 1'b0;
  assign ras_full_c  = 1'b0;
  assign ras_empty_c = 1'b1;
  assign ras_top_c   = '0;
  assign ras_unused  = ^{ret_en, ras_push_c, ras_pop_c, ras_clear_c, pc_inc_c, RAS_DEPTH[0]};
`endif

  assign base_c = (32'(prog_sel) < NUM_PROGS) ? PC_W'(prog_base_at(32'(prog_sel)))
                                              : PC_W'(prog_base_at(0));

  // Leaving LOAD executes the first sequential step, so PC advances on that edge.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    ras_push_c  = 1'b0;
    ras_pop_c   = 1'b0;
    ras_clear_c = 1'b0;
    pc_inc_c    = pc_q + PC_W'(1);

    if (start) begin
      state_d     = LOAD;
      pc_d        = base_c;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      ras_clear_c = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          state_d = RUN;
          pc_d    = pc_inc_c;
        end
        RUN: begin
          if (halt_en) begin
            state_d = HALT;
          end else if (ret_req_c) begin
            if (ras_empty_c) begin
              pc_d  = pc_inc_c;
              unf_d = 1'b1;
            end else begin
              pc_d      = ras_top_c;
              ras_pop_c = 1'b1;
            end
          end else if (call_en) begin
            pc_d       = target;
            ras_push_c = RAS_ON;
            if (ras_full_c) ovf_d = 1'b1;
          end else if (branch_en && alu_flag) begin
            pc_d = br_abs ? target : pc_q + target;
          end else begin
            pc_d = pc_inc_c;
          end
        end
        default: ;
      endcase
    end

    done_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign prog_ctr = pc_q;
  assign done     = done_q;
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus random traffic against a queue-based model.
module tb_pc_seq;

  localparam int PCW   = 11;
  localparam int DEPTH = 4;
  localparam int MODN  = 2048;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [1:0]      prog_sel;
  logic            branch_en, alu_flag, br_abs, call_en, ret_en, halt_en;
  logic [PCW-1:0]  target;
  logic [PCW-1:0]  prog_ctr;
  logic            done, ras_ovf, ras_unf;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle, 1 loading, 2 running, 3 halted.
  int m_mode;
  int m_pc;
  int m_ovf, m_unf;
  int m_stack[$];

  pc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prog_sel  (prog_sel),
    .branch_en (branch_en),
    .alu_flag  (alu_flag),
    .br_abs    (br_abs),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .halt_en   (halt_en),
    .target    (target),
    .prog_ctr  (prog_ctr),
    .done      (done),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  function automatic int base_of(input int sel);
    if (sel == 1) return 256;
    if (sel == 2) return 512;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ovf = 0; m_unf = 0;
    m_stack.delete();
  endtask

  task automatic model_step();
    bit ras_on;
`ifdef PC_SEQ_RAS_EN
    ras_on = 1'b1;
`else
    ras_on = 1'b0;
`endif
    if (start) begin
      m_mode = 1; m_pc = base_of(int'(prog_sel));
      m_ovf = 0; m_unf = 0; m_stack.delete();
    end else if (m_mode == 1) begin
      m_mode = 2; m_pc = (m_pc + 1) % MODN;
    end else if (m_mode == 2) begin
      if (halt_en) m_mode = 3;
      else if (ras_on && ret_en) begin
        if (m_stack.size() == 0) begin m_pc = (m_pc + 1) % MODN; m_unf = 1; end
        else m_pc = m_stack.pop_back();
      end else if (call_en) begin
        if (ras_on) begin
          if (m_stack.size() == DEPTH) begin void'(m_stack.pop_front()); m_ovf = 1; end
          m_stack.push_back((m_pc + 1) % MODN);
        end
        m_pc = int'(target);
      end else if (branch_en && alu_flag) begin
        m_pc = br_abs ? int'(target) : (m_pc + int'(target)) % MODN;
      end else m_pc = (m_pc + 1) % MODN;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},   32'(prog_ctr), 32'(m_pc));
    check({tag, ".done"}, 32'(done),     32'(m_mode == 3));
    check({tag, ".ovf"},  32'(ras_ovf),  32'(m_ovf));
    check({tag, ".unf"},  32'(ras_unf),  32'(m_unf));
  endtask

  // One clock: drive at negedge, advance the model, sample 1 time unit after the rising edge.
  task automatic cyc(input string tag, input bit st, input int sel, input bit br, input bit fl,
                     input bit ab, input bit ca, input bit re, input bit ha, input int tg);
    @(negedge clk);
    start = st; prog_sel = 2'(sel); branch_en = br; alu_flag = fl; br_abs = ab;
    call_en = ca; ret_en = re; halt_en = ha; target = PCW'(tg);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic nop(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump_abs(input string tag, input int tg);
    cyc(tag, 0, 0, 1, 1, 1, 0, 0, 0, tg);
  endtask

  initial begin
    reset = 1'b1; start = 0; prog_sel = 0; branch_en = 0; alu_flag = 0; br_abs = 0;
    call_en = 0; ret_en = 0; halt_en = 0; target = '0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    nop("idle_hold");

    // Entry point held for the whole of start, then sequential stepping.
    cyc("load1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("load2", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("load3", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("load_base", 32'(prog_ctr), 32'd256);
    nop("run257");
    check("run_257", 32'(prog_ctr), 32'd257);
    nop("run258");
    check("run_258", 32'(prog_ctr), 32'd258);

    // Branches.
    jump_abs("to20", 20);
    cyc("br_rel_neg", 0, 0, 1, 1, 0, 0, 0, 0, 'h7FE);
    check("br_rel_18", 32'(prog_ctr), 32'd18);
    cyc("br_abs100", 0, 0, 1, 1, 1, 0, 0, 0, 100);
    check("br_abs_100", 32'(prog_ctr), 32'd100);
    cyc("br_not_taken", 0, 0, 1, 0, 1, 0, 0, 0, 500);
    check("br_nt_101", 32'(prog_ctr), 32'd101);

    // Wrap-around.
    jump_abs("to2047", 2047);
    nop("wrap_inc");
    check("wrap_0", 32'(prog_ctr), 32'd0);
    jump_abs("to2040", 2040);
    cyc("wrap_rel", 0, 0, 1, 1, 0, 0, 0, 0, 10);
    check("wrap_2", 32'(prog_ctr), 32'd2);

    // Call / return.
    jump_abs("to30", 30);
    cyc("call200", 0, 0, 0, 0, 0, 1, 0, 0, 200);
    check("call_200", 32'(prog_ctr), 32'd200);
    cyc("ret", 0, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef PC_SEQ_RAS_EN
    check("ret_31", 32'(prog_ctr), 32'd31);
    for (int i = 0; i < 5; i++) cyc("nest_call", 0, 0, 0, 0, 0, 1, 0, 0, 300 + 100 * i);
    check("nest_ovf", 32'(ras_ovf), 32'd1);
    cyc("call_ret_both", 0, 0, 0, 0, 0, 1, 1, 0, 1000);
    check("both_is_ret", 32'(prog_ctr), 32'd601);
    for (int i = 0; i < 4; i++) cyc("nest_ret", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("unf_set", 32'(ras_unf), 32'd1);
`else
    check("ret_noras_201", 32'(prog_ctr), 32'd201);
    for (int i = 0; i < 6; i++) cyc("noras_call", 0, 0, 0, 0, 0, 1, 0, 0, 300 + i);
    cyc("noras_ret", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("noras_ovf0", 32'(ras_ovf), 32'd0);
    check("noras_unf0", 32'(ras_unf), 32'd0);
`endif

    // Halt has top priority; HALT ignores requests; start clears.
    cyc("halt_prio", 0, 0, 1, 1, 1, 1, 1, 1, 77);
    check("halt_done", 32'(done), 32'd1);
    cyc("halt_ign", 0, 0, 1, 1, 1, 1, 1, 0, 55);
    nop("halt_hold");
    cyc("restart", 1, 2, 0, 0, 0, 0, 0, 0, 0);
    check("restart_done0", 32'(done), 32'd0);
    check("restart_512", 32'(prog_ctr), 32'd512);
    cyc("sel_oob", 1, 3, 0, 0, 0, 0, 0, 0, 0);
    check("sel_oob_0", 32'(prog_ctr), 32'd0);
    nop("oob_run");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", $urandom_range(0, 15) == 0, $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 19) == 0, int'($urandom_range(0, 2047)));
    end

    // Asynchronous reset in the middle of a run.
    cyc("pre_rst_load", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop("pre_rst_run");
    cyc("pre_rst_call", 0, 0, 0, 0, 0, 1, 0, 0, 700);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    nop("post_rst_idle");
    check("post_rst_pc0", 32'(prog_ctr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
